pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, max cycles of memory stall before timeout.
REQ-002 SHALL have port clk  input  1  core clock; all state on rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ex_jump_en_i  input  1  jump/branch-taken request from EX.
REQ-005 SHALL have port ex_jump_base_i  input  32  jump base address from EX.
REQ-006 SHALL have port ex_jump_ofst_i  input  32  jump offset from EX.
REQ-007 SHALL have port ex_hold_flag_i  input  1  EX multi-cycle hold request.
REQ-008 SHALL have port id_lduse_i  input  1  load-use hazard detected in ID.
REQ-009 SHALL have port mem_busy_i  input  1  data memory not ready.
REQ-010 SHALL have port jump_en_o  output  1  PC redirect strobe.
REQ-011 SHALL have port jump_addr_o  output  32  PC redirect target.
REQ-012 SHALL have port hold_o  output  4  hold vector {ex_mem, id_ex, if_id, pc}.
REQ-013 SHALL have port flush_o  output  2  flush vector {id_ex, if_id}.
REQ-014 SHALL have port mem_tmo_o  output  1  one-cycle memory-timeout pulse.

Function
REQ-015 SHALL form target = (base + ofst) mod 2^32 with bit0 forced to 0.
REQ-016 SHALL implement FSM states RUN, FLUSH, MEMWAIT, LDUSE; priority mem_busy > jump > ex_hold > lduse.
REQ-017 RUN, no requests: hold_o=0, flush_o=0, jump_en_o=0.
REQ-018 RUN, ex_jump_en_i, no mem_busy: same cycle jump_en_o=1, jump_addr_o=target, flush_o=2'b11; next state FLUSH.
REQ-019 FLUSH lasts exactly one cycle: flush_o=2'b01 (wrong-path fetch from synchronous ROM), jump_en_o=0; a new jump in FLUSH is ignored; next RUN.
REQ-020 RUN, ex_hold_flag_i, no jump/mem_busy: hold_o=4'b0111 combinationally while asserted; state stays RUN.
REQ-021 RUN, id_lduse_i only: hold_o=4'b0011, flush_o=2'b10 for one cycle; next LDUSE; LDUSE outputs all 0 and returns to RUN regardless of id_lduse_i.
REQ-022 mem_busy_i in any state: hold_o=4'b1111, flush_o=0, jump_en_o=0; next MEMWAIT.
REQ-023 MEMWAIT: hold_o=4'b1111 while mem_busy_i; 8-bit counter increments per busy cycle.
REQ-024 Counter reaching MEM_TIMEOUT: mem_tmo_o=1 one cycle, counter clears, next RUN, holds drop, even if mem_busy_i high.
REQ-025 ex_jump_en_i with mem_busy_i: target latched into pending register (first request wins, later ignored).
REQ-026 mem_busy_i deasserting with pending jump: that cycle jump_en_o=1, jump_addr_o=pending target, flush_o=2'b11, pending cleared, next FLUSH.
REQ-027 Timeout discards any pending jump.
REQ-028 jump_addr_o holds last issued target when jump_en_o=0.
REQ-029 Counter clears on every MEMWAIT exit.

Reset
REQ-030 rstn low SHALL asynchronously force state RUN, counter 0, pending cleared, jump_addr_o=CpuResetAddr (0x0), all other outputs 0.
REQ-031 Reset mid-MEMWAIT or mid-FLUSH SHALL drop all holds/flushes immediately with no pending jump issued after release.

Structure
REQ-032 Shared defines file SHALL hold state encodings, hold/flush bit positions, HoldEnable/HoldDisable, JumpEnable/JumpDisable, CpuResetAddr.
REQ-033 Memory-stall counter/timeout SHALL be sub-module pipe_stall_tmr (clear, count-enable, terminal pulse).

Verification
REQ-034 base=0x100, ofst=0x20, jump 1 cycle -> jump_en_o=1, addr=0x120, flush 11, then flush 01, then 00.
REQ-035 base=0x1003, ofst=0x4 (JALR) -> jump_addr_o=0x1006.
REQ-036 mem_busy 3 cycles with jump (base 0x200, ofst 0x8) in cycle 1 -> hold 1111 x3, then jump_en_o=1, addr 0x208, flush 11.
REQ-037 MEM_TIMEOUT=4, mem_busy held 10 cycles -> mem_tmo_o pulse after 4th busy cycle, holds drop, new MEMWAIT next cycle.
REQ-038 id_lduse_i held 2 cycles -> hold 0011/flush 10 one cycle, then one all-zero LDUSE cycle, then repeat.
REQ-039 rstn low during MEMWAIT with pending jump -> outputs 0 immediately, no jump_en_o after release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM encoding, hold/flush
// vector bit positions, enable constants and the jump-target helper.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MEMWAIT = 2'd2,
        ST_LDUSE   = 2'd3
    } state_e;

    // hold_o = {ex_mem, id_ex, if_id, pc}
    localparam int HOLD_PC     = 0;
    localparam int HOLD_IF_ID  = 1;
    localparam int HOLD_ID_EX  = 2;
    localparam int HOLD_EX_MEM = 3;

    // flush_o = {id_ex, if_id}
    localparam int FLUSH_IF_ID = 0;
    localparam int FLUSH_ID_EX = 1;

    localparam logic HoldEnable  = 1'b1;
    localparam logic HoldDisable = 1'b0;
    localparam logic JumpEnable  = 1'b1;
    localparam logic JumpDisable = 1'b0;

    localparam logic [31:0] CpuResetAddr = 32'h0000_0000;

    localparam int TMR_W = 8;

    // Wrap-around sum with bit 0 cleared, as JALR requires.
    function automatic logic [31:0] jump_target(input logic [31:0] base,
                                                input logic [31:0] ofst);
        logic [31:0] sum;
        sum    = base + ofst;
        sum[0] = 1'b0;
        return sum;
    endfunction

endpackage

// File: rtl/pipe_stall_tmr.sv
// Memory-stall cycle counter: counts enabled cycles, flags the terminal count
// and is cleared explicitly by the controller on every stall exit.
module pipe_stall_tmr
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr_i,
    input  logic cnt_en_i,
    output logic done_o
);

    localparam logic [TMR_W-1:0] TermCnt = TMR_W'(TIMEOUT);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge inputs regardless of process order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == TermCnt);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: arbitrates memory stalls, jumps, EX holds and
// load-use bubbles into hold/flush vectors and a PC redirect.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ex_jump_en_i,
    input  logic [31:0] ex_jump_base_i,
    input  logic [31:0] ex_jump_ofst_i,
    input  logic        ex_hold_flag_i,
    input  logic        id_lduse_i,
    input  logic        mem_busy_i,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic [3:0]  hold_o,
    output logic [1:0]  flush_o,
    output logic        mem_tmo_o
);

    state_e      state_q, state_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic [31:0] last_addr_q, last_addr_d;

    logic        tmr_clr, tmr_en, tmr_done;
    logic        do_run, stall, capture_ok, issue;
    logic [31:0] issue_addr;
    logic [31:0] ex_target;

    assign ex_target = jump_target(ex_jump_base_i, ex_jump_ofst_i);

    pipe_stall_tmr #(
        .TIMEOUT (MEM_TIMEOUT)
    ) u_stall_tmr (
        .clk      (clk),
        .rstn     (rstn),
        .clr_i    (tmr_clr),
        .cnt_en_i (tmr_en),
        .done_o   (tmr_done)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;
        last_addr_d = last_addr_q;
        hold_o      = '0;
        flush_o     = '0;
        jump_en_o   = JumpDisable;
        jump_addr_o = last_addr_q;
        mem_tmo_o   = 1'b0;
        tmr_clr     = 1'b0;
        tmr_en      = 1'b0;
        do_run      = 1'b0;
        stall       = 1'b0;
        capture_ok  = 1'b0;
        issue       = 1'b0;
        issue_addr  = pend_addr_q;

        case (state_q)
            ST_MEMWAIT: begin
                if (tmr_done) begin
                    // Timeout wins over a still-busy memory and drops any
                    // jump that was waiting for the stall to end.
                    mem_tmo_o  = 1'b1;
                    tmr_clr    = 1'b1;
                    pend_vld_d = 1'b0;
                    state_d    = ST_RUN;
                end else if (!mem_busy_i) begin
                    tmr_clr = 1'b1;
                    if (pend_vld_q) begin
                        issue = 1'b1;
                    end else begin
                        do_run = 1'b1;
                    end
                end else begin
                    stall      = 1'b1;
                    capture_ok = 1'b1;
                end
            end
            ST_FLUSH: begin
                // The jump already issued; the synchronous ROM still returns
                // one wrong-path word, so only IF/ID is squashed here.
                if (mem_busy_i) begin
                    stall = 1'b1;
                end else begin
                    flush_o[FLUSH_IF_ID] = 1'b1;
                    state_d              = ST_RUN;
                end
            end
            ST_LDUSE: begin
                if (mem_busy_i) begin
                    stall = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                do_run = 1'b1;
            end
        endcase

        if (do_run) begin
            state_d = ST_RUN;
            if (mem_busy_i) begin
                stall      = 1'b1;
                capture_ok = 1'b1;
            end else if (ex_jump_en_i) begin
                issue      = 1'b1;
                issue_addr = ex_target;
            end else if (ex_hold_flag_i) begin
                hold_o[HOLD_ID_EX] = HoldEnable;
                hold_o[HOLD_IF_ID] = HoldEnable;
                hold_o[HOLD_PC]    = HoldEnable;
            end else if (id_lduse_i) begin
                hold_o[HOLD_IF_ID]   = HoldEnable;
                hold_o[HOLD_PC]      = HoldEnable;
                flush_o[FLUSH_ID_EX] = 1'b1;
                state_d              = ST_LDUSE;
            end
        end

        if (stall) begin
            hold_o  = {4{HoldEnable}};
            tmr_en  = 1'b1;
            state_d = ST_MEMWAIT;
            if (capture_ok && ex_jump_en_i && !pend_vld_q) begin
                pend_vld_d  = 1'b1;
                pend_addr_d = ex_target;
            end
        end

        if (issue) begin
            jump_en_o   = JumpEnable;
            jump_addr_o = issue_addr;
            flush_o     = 2'b11;
            last_addr_d = issue_addr;
            pend_vld_d  = 1'b0;
            state_d     = ST_FLUSH;
        end

        // Outputs are partly combinational from live inputs, so they are
        // forced quiet for as long as reset is held, not just after an edge.
        if (!rstn) begin
            hold_o      = {4{HoldDisable}};
            flush_o     = '0;
            jump_en_o   = JumpDisable;
            jump_addr_o = CpuResetAddr;
            mem_tmo_o   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_RUN;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= CpuResetAddr;
            last_addr_q <= CpuResetAddr;
        end else begin
            state_q     <= state_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            last_addr_q <= last_addr_d;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: each vector pushes its hand-computed response
// into a scoreboard queue; a monitor pops and compares on the falling edge.
module tb_pipe_ctrl;

    typedef struct {
        string       name;
        logic [3:0]  hold;
        logic [1:0]  flush;
        logic        jen;
        logic [31:0] addr;
        logic        tmo;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ex_jump_en_i = 1'b0;
    logic [31:0] ex_jump_base_i = '0;
    logic [31:0] ex_jump_ofst_i = '0;
    logic        ex_hold_flag_i = 1'b0;
    logic        id_lduse_i = 1'b0;
    logic        mem_busy_i = 1'b0;
    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic [3:0]  hold_o;
    logic [1:0]  flush_o;
    logic        mem_tmo_o;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .MEM_TIMEOUT (4)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .ex_jump_en_i   (ex_jump_en_i),
        .ex_jump_base_i (ex_jump_base_i),
        .ex_jump_ofst_i (ex_jump_ofst_i),
        .ex_hold_flag_i (ex_hold_flag_i),
        .id_lduse_i     (id_lduse_i),
        .mem_busy_i     (mem_busy_i),
        .jump_en_o      (jump_en_o),
        .jump_addr_o    (jump_addr_o),
        .hold_o         (hold_o),
        .flush_o        (flush_o),
        .mem_tmo_o      (mem_tmo_o)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One clock cycle of stimulus plus the response expected during it.
    task automatic cyc(input string nm, input logic rst, input logic jen,
                       input logic [31:0] base, input logic [31:0] ofst,
                       input logic exh, input logic ldu, input logic bsy,
                       input logic [3:0] eh, input logic [1:0] ef, input logic ej,
                       input logic [31:0] ea, input logic et);
        exp_t e;
        @(posedge clk);
        #1;
        rstn           = rst;
        ex_jump_en_i   = jen;
        ex_jump_base_i = base;
        ex_jump_ofst_i = ofst;
        ex_hold_flag_i = exh;
        id_lduse_i     = ldu;
        mem_busy_i     = bsy;
        e.name  = nm;
        e.hold  = eh;
        e.flush = ef;
        e.jen   = ej;
        e.addr  = ea;
        e.tmo   = et;
        sb_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.name, ".hold"},  32'(hold_o),      32'(e.hold));
                check({e.name, ".flush"}, 32'(flush_o),     32'(e.flush));
                check({e.name, ".jen"},   32'(jump_en_o),   32'(e.jen));
                check({e.name, ".addr"},  jump_addr_o,      e.addr);
                check({e.name, ".tmo"},   32'(mem_tmo_o),   32'(e.tmo));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        //   name          rst jen base          ofst          exh ldu bsy  hold     flush  jen  addr          tmo
        cyc("rst_idle",    0,  0,  32'h0,        32'h0,        0,  0,  0,   4'b0000, 2'b00, 0,   32'h0,        0);
        cyc("rst_busy",    0,  1,  32'h100,      32'h4,        1,  1,  1,   4'b0000, 2'b00, 0,   32'h0,        0);
        cyc("idle0",       1,  0,  32'h0,        32'h0,        0,  0,  0,   4'b0000, 2'b00, 0,   32'h0,        0);
        // Plain jump, then FLUSH (new jump ignored), then back to RUN.
        cyc("jmp120",      1,  1,  32'h100,      32'h20,       0,  0,  0,   4'b0000, 2'b11, 1,   32'h120,      0);
        cyc("flush_ign",   1,  1,  32'h500,      32'h0,        0,  0,  0,   4'b0000, 2'b01, 0,   32'h120,      0);
        cyc("post_jmp",    1,  0,  32'h0,        32'h0,        0,  0,  0,   4'b0000, 2'b00, 0,   32'h120,      0);
        // JALR-style odd sum: bit 0 cleared.
        cyc("jalr1006",    1,  1,  32'h1003,     32'h4,        0,  0,  0,   4'b0000, 2'b11, 1,   32'h1006,     0);
        cyc("jalr_flush",  1,  0,  32'h0,        32'h0,        0,  0,  0,   4'b0000, 2'b01, 0,   32'h1006,     0);
        cyc("wrap_jmp",    1,  1,  32'hFFFF_FFF0, 32'h15,      0,  0,  0,   4'b0000, 2'b11, 1,   32'h4,        0);
        cyc("wrap_flush",  1,  0,  32'h0,        32'h0,        0,  0,  0,   4'b0000, 2'b01, 0,   32'h4,        0);
        // EX hold, including priority over a simultaneous load-use.
        cyc("exhold1",     1,  0,  32'h0,        32'h0,        1,  0,  0,   4'b0111, 2'b00, 0,   32'h4,        0);
        cyc("exhold2",     1,  0,  32'h0,        32'h0,        1,  0,  0,   4'b0111, 2'b00, 0,   32'h4,        0);
        cyc("exhold_ldu",  1,  0,  32'h0,        32'h0,        1,  1,  0,   4'b0111, 2'b00, 0,   32'h4,        0);
        // Load-use held: bubble, empty LDUSE cycle, repeat.
        cyc("ldu1",        1,  0,  32'h0,        32'h0,        0,  1,  0,   4'b0011, 2'b10, 0,   32'h4,        0);
        cyc("ldu1_st",     1,  0,  32'h0,        32'h0,        0,  1,  0,   4'b0000, 2'b00, 0,   32'h4,        0);
        cyc("ldu2",        1,  0,  32'h0,        32'h0,        0,  1,  0,   4'b0011, 2'b10, 0,   32'h4,        0);
        cyc("ldu2_st",     1,  0,  32'h0,        32'h0,        0,  1,  0,   4'b0000, 2'b00, 0,   32'h4,        0);
        cyc("idle1",       1,  0,  32'h0,        32'h0,        0,  0,  0,   4'b0000, 2'b00, 0,   32'h4,        0);
        // Busy with jump in first cycle; a later jump is ignored.
        cyc("mb_jmp",      1,  1,  32'h200,      32'h8,        0,  0,  1,   4'b1111, 2'b00, 0,   32'h4,        0);
        cyc("mb_jmp2",     1,  1,  32'h900,      32'h0,        0,  0,  1,   4'b1111, 2'b00, 0,   32'h4,        0);
        cyc("mb3",         1,  0,  32'h0,        32'h0,        0,  0,  1,   4'b1111, 2'b00, 0,   32'h4,        0);
        cyc("mb_release",  1,  0,  32'h0,        32'h0,        0,  0,  0,   4'b0000, 2'b11, 1,   32'h208,      0);
        cyc("mb_flush",    1,  0,  32'h0,        32'h0,        0,  0,  0,   4'b0000, 2'b01, 0,   32'h208,      0);
        cyc("idle2",       1,  0,  32'h0,        32'h0,        0,  0,  0,   4'b0000, 2'b00, 0,   32'h208,      0);
        // Busy for 10 cycles with timeout 4: pulse on cycles 5 and 10.
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++)
                cyc("tmo_busy",1,  0,  32'h0,        32'h0,        0,  0,  1,   4'b1111, 2'b00, 0,   32'h208,      0);
            cyc("tmo_pulse",   1,  0,  32'h0,        32'h0,        0,  0,  1,   4'b0000, 2'b00, 0,   32'h208,      1);
        end
        cyc("idle3",       1,  0,  32'h0,        32'h0,        0,  0,  0,   4'b0000, 2'b00, 0,   32'h208,      0);
        // Timeout discards the pending jump.
        cyc("tp_jmp",      1,  1,  32'h300,      32'h10,       0,  0,  1,   4'b1111, 2'b00, 0,   32'h208,      0);
        for (int k = 0; k < 3; k++)
            cyc("tp_busy", 1,  0,  32'h0,        32'h0,        0,  0,  1,   4'b1111, 2'b00, 0,   32'h208,      0);
        cyc("tp_pulse",    1,  0,  32'h0,        32'h0,        0,  0,  1,   4'b0000, 2'b00, 0,   32'h208,      1);
        cyc("tp_nojmp",    1,  0,  32'h0,        32'h0,        0,  0,  0,   4'b0000, 2'b00, 0,   32'h208,      0);
        // Stall exit with no pending jump but a live one; busy during FLUSH.
        cyc("mw_busy",     1,  0,  32'h0,        32'h0,        0,  0,  1,   4'b1111, 2'b00, 0,   32'h208,      0);
        cyc("mw_exit_jmp", 1,  1,  32'h40,       32'h4,        0,  0,  0,   4'b0000, 2'b11, 1,   32'h44,       0);
        cyc("mw_flush",    1,  0,  32'h0,        32'h0,        0,  0,  0,   4'b0000, 2'b01, 0,   32'h44,       0);
        cyc("jmp80",       1,  1,  32'h80,       32'h0,        0,  0,  0,   4'b0000, 2'b11, 1,   32'h80,       0);
        cyc("flush_busy",  1,  0,  32'h0,        32'h0,        0,  0,  1,   4'b1111, 2'b00, 0,   32'h80,       0);
        cyc("mw_exit_idle",1,  0,  32'h0,        32'h0,        0,  0,  0,   4'b0000, 2'b00, 0,   32'h80,       0);
        // Reset during a stall with a pending jump.
        cyc("rp_jmp",      1,  1,  32'h600,      32'h2,        0,  0,  1,   4'b1111, 2'b00, 0,   32'h80,       0);
        cyc("rp_busy",     1,  0,  32'h0,        32'h0,        0,  0,  1,   4'b1111, 2'b00, 0,   32'h80,       0);
        cyc("rp_reset",    0,  0,  32'h0,        32'h0,        0,  0,  1,   4'b0000, 2'b00, 0,   32'h0,        0);
        cyc("rp_release",  1,  0,  32'h0,        32'h0,        0,  0,  0,   4'b0000, 2'b00, 0,   32'h0,        0);
        cyc("rp_idle",     1,  0,  32'h0,        32'h0,        0,  0,  0,   4'b0000, 2'b00, 0,   32'h0,        0);

        @(posedge clk);
        #1;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
